mem_fetch_ctrl: RTL and testbench



---
 rtl/mem_fetch_pkg.sv | 21 ++
 rtl/mem_req_fifo.sv | 45 ++++
 rtl/mem_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fetch_pkg.sv
// rtl/mem_fetch_pkg.sv - shared state encoding and data pattern for the memory fetch controller
package mem_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_BASE_PATTERN = 32'hCAFEBABE;
    localparam int          PATTERN_WIDTH        = 64;

    // Memory contents are the seed XOR the zero-extended address; callers truncate to their width.
    function automatic logic [PATTERN_WIDTH-1:0] fetch_pattern(
        input logic [PATTERN_WIDTH-1:0] base,
        input logic [PATTERN_WIDTH-1:0] addr
    );
        return base ^ addr;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - request address FIFO with wrap-bit pointers and async reset
module mem_req_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_en;
    logic             pop_en;

    // Same index with differing wrap bits means every slot is occupied.
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_fetch_ctrl.sv
// rtl/mem_fetch_ctrl.sv - in-order main-memory fetch engine with programmable response latency
module mem_fetch_ctrl
    import mem_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 11,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    LATENCY      = 4,
    parameter int                    QUEUE_DEPTH  = 2,
    parameter logic [DATA_WIDTH-1:0] BASE_PATTERN = DATA_WIDTH'(DEFAULT_BASE_PATTERN),
    localparam int                   PEND_W       = $clog2(QUEUE_DEPTH + 1) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [PEND_W-1:0]     pending,
    output logic                  busy
);

    localparam logic [7:0] LAT_START = 8'(LATENCY - 2);

    fetch_state_t          state, state_d;
    logic [7:0]            cnt, cnt_d;
    logic                  rsp_valid_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_d;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic [ADDR_WIDTH-1:0] svc_addr, svc_addr_d;
    logic [DATA_WIDTH-1:0] svc_data, svc_data_d;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  accept;
    logic                  handshake;

    assign req_ready = !fifo_full;
    assign accept    = req_valid && !fifo_full;
    assign handshake = rsp_valid && rsp_ready;
    assign busy      = (pending != '0);
    assign head_data = DATA_WIDTH'(fetch_pattern(PATTERN_WIDTH'(BASE_PATTERN), PATTERN_WIDTH'(head_addr)));

    mem_req_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (req_addr),
        .pop       (fifo_pop),
        .pop_data  (head_addr),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            svc_addr  <= '0;
            svc_data  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_addr  <= rsp_addr_d;
            rsp_data  <= rsp_data_d;
            svc_addr  <= svc_addr_d;
            svc_data  <= svc_data_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rsp_valid_d = rsp_valid;
        rsp_addr_d  = rsp_addr;
        rsp_data_d  = rsp_data;
        svc_addr_d  = svc_addr;
        svc_data_d  = svc_data;
        fifo_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    svc_addr_d = head_addr;
                    svc_data_d = head_data;
                    cnt_d      = LAT_START;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 8'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = svc_addr;
                    rsp_data_d  = svc_data;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // A queued request starts service on the handshake edge itself.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        svc_addr_d = head_addr;
                        svc_data_d = head_data;
                        cnt_d      = LAT_START;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            case ({accept, handshake})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// tb/tb_mem_fetch_ctrl.sv - self-checking bench for mem_fetch_ctrl against a queue-based timing model
module tb_mem_fetch_ctrl;

    localparam int          LAT  = 4;
    localparam int          QD   = 2;
    localparam logic [31:0] BASE = 32'hCAFEBABE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, busy;
    logic [10:0] req_addr = '0, rsp_addr;
    logic [31:0] rsp_data;
    logic [2:0]  pending;

    logic        req_valid_b = 1'b0, req_ready_b, rsp_valid_b, rsp_ready_b = 1'b0, busy_b;
    logic [10:0] req_addr_b = '0, rsp_addr_b;
    logic [31:0] rsp_data_b;
    logic [2:0]  pending_b;

    always #5 clk = ~clk;

    mem_fetch_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .pending(pending), .busy(busy)
    );

    mem_fetch_ctrl #(.LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_addr(rsp_addr_b), .rsp_data(rsp_data_b),
        .pending(pending_b), .busy(busy_b)
    );

    typedef struct {
        logic [10:0] addr;
        int          e;
    } req_t;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
        int          lat;
    } vec_t;

    req_t q[$];
    req_t hs_log[$];
    int   edge_n, last_h;
    int   n_pass = 0, n_total = 0;
    logic acc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
    endtask

    // Model: head starts service at max(accept+1, previous handshake edge); valid LAT-1 edges later.
    task automatic cycle(input logic v, input logic [10:0] a, input logic r, output logic accepted);
        int   s;
        logic in_svc, ev, er, hs;
        req_t head;
        req_valid = v;
        req_addr  = a;
        rsp_ready = r;
        in_svc = 1'b0;
        ev     = 1'b0;
        if (q.size() > 0) begin
            s      = (q[0].e + 1 > last_h) ? q[0].e + 1 : last_h;
            in_svc = (s <= edge_n);
            ev     = in_svc && (edge_n >= s + LAT - 1);
        end
        er = (q.size() - int'(in_svc)) < QD;
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("pending", 32'(pending), 32'(q.size()));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("req_ready", 32'(req_ready), 32'(er));
        if (ev) begin
            chk("rsp_addr", 32'(rsp_addr), 32'(q[0].addr));
            chk("rsp_data", rsp_data, BASE ^ {21'b0, q[0].addr});
        end
        accepted = v && er;
        hs       = ev && r;
        @(posedge clk);
        edge_n++;
        if (hs) begin
            head = q.pop_front();
            hs_log.push_back('{head.addr, edge_n});
            last_h = edge_n;
        end
        if (accepted) q.push_back('{a, edge_n});
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt[6];
        logic [10:0] fill_addr[4];
        int          lat, idx;
        logic [10:0] ba[$];
        logic [31:0] bd[$];
        int          be[$];

        vt[0] = '{11'h123, 32'hCAFEBB9D, 4};
        vt[1] = '{11'h000, 32'hCAFEBABE, 4};
        vt[2] = '{11'h7FF, 32'hCAFEBD41, 4};
        vt[3] = '{11'h555, 32'hCAFEBFEB, 4};
        vt[4] = '{11'h2AA, 32'hCAFEB814, 4};
        vt[5] = '{11'h010, 32'hCAFEBAAE, 4};
        fill_addr[0] = 11'h001; fill_addr[1] = 11'h002;
        fill_addr[2] = 11'h003; fill_addr[3] = 11'h004;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        edge_n = 0;
        last_h = 0;

        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vt[i].addr, 1'b1, acc);
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                cycle(1'b0, 11'h0, 1'b1, acc);
                if (rsp_valid) begin lat = k; break; end
            end
            chk("vec_latency", 32'(lat), 32'(vt[i].lat));
            chk("vec_rsp_addr", 32'(rsp_addr), 32'(vt[i].addr));
            chk("vec_rsp_data", rsp_data, vt[i].data);
            cycle(1'b0, 11'h0, 1'b1, acc);
            cycle(1'b0, 11'h0, 1'b1, acc);
            chk("vec_pending_drained", 32'(pending), 32'd0);
        end

        // Fill the queue under backpressure, then release.
        hs_log.delete();
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            cycle(idx < 4, (idx < 4) ? fill_addr[idx] : 11'h0, c >= 8, acc);
            if (acc) idx++;
            if (c == 7) begin
                chk("fill_pending", 32'(pending), 32'd3);
                chk("fill_req_ready", 32'(req_ready), 32'd0);
            end
            if (hs_log.size() == 4) break;
        end
        chk("fill_count", 32'(hs_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++)
            chk("fill_order", 32'(hs_log[i].addr), 32'(fill_addr[i]));
        for (int i = 1; i < 4 && i < hs_log.size(); i++)
            chk("fill_spacing", 32'(hs_log[i].e - hs_log[i-1].e), 32'(LAT));
        repeat (2) cycle(1'b0, 11'h0, 1'b1, acc);

        // Long backpressure hold.
        cycle(1'b1, 11'h2AA, 1'b0, acc);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 11'h0, 1'b0, acc);
            if (rsp_valid) begin lat = k; break; end
        end
        chk("hold_latency", 32'(lat), 32'(LAT));
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 11'h0, 1'b0, acc);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_addr", 32'(rsp_addr), 32'h2AA);
            chk("hold_data", rsp_data, 32'hCAFEB814);
        end
        hs_log.delete();
        cycle(1'b0, 11'h0, 1'b1, acc);
        chk("hold_valid_dropped", 32'(rsp_valid), 32'd0);
        cycle(1'b0, 11'h0, 1'b1, acc);
        chk("hold_one_handshake", 32'(hs_log.size()), 32'd1);
        chk("hold_pending", 32'(pending), 32'd0);

        // Reset with one request in service and two queued.
        cycle(1'b1, 11'h055, 1'b0, acc);
        cycle(1'b1, 11'h066, 1'b0, acc);
        cycle(1'b1, 11'h077, 1'b0, acc);
        chk("midrst_pending_before", 32'(pending), 32'd3);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        q.delete();
        repeat (2) begin @(posedge clk); edge_n++; end
        #1;
        rst = 1'b0;
        last_h = edge_n;
        hs_log.delete();
        repeat (12) cycle(1'b0, 11'h0, 1'b1, acc);
        chk("midrst_no_response", 32'(hs_log.size()), 32'd0);
        cycle(1'b1, 11'h010, 1'b1, acc);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 11'h0, 1'b1, acc);
            if (rsp_valid) begin lat = k; break; end
        end
        chk("postrst_latency", 32'(lat), 32'(LAT));
        chk("postrst_data", rsp_data, 32'hCAFEBAAE);
        chk("postrst_addr", 32'(rsp_addr), 32'h010);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), $urandom_range(0, 3) != 0, acc);
        repeat (40) cycle(1'b0, 11'h0, 1'b1, acc);
        chk("random_drained", 32'(pending), 32'd0);

        // LATENCY=2 instance: single request, then a streaming run.
        chk("b_req_ready", 32'(req_ready_b), 32'd1);
        req_valid_b = 1'b1;
        req_addr_b  = 11'h0AB;
        rsp_ready_b = 1'b1;
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_b) begin lat = k; break; end
        end
        chk("b_latency", 32'(lat), 32'd2);
        chk("b_data", rsp_data_b, 32'hCAFEBA15);
        @(posedge clk);
        #1;
        chk("b_pending", 32'(pending_b), 32'd0);

        idx = 0;
        for (int c = 0; c < 60; c++) begin
            logic acc_b;
            req_valid_b = (idx < 6);
            req_addr_b  = 11'h100 + 11'(idx);
            acc_b       = req_valid_b && req_ready_b;
            if (rsp_valid_b) begin
                ba.push_back(rsp_addr_b);
                bd.push_back(rsp_data_b);
                be.push_back(c);
            end
            @(posedge clk);
            if (acc_b) idx++;
            #1;
            if (ba.size() == 6) break;
        end
        req_valid_b = 1'b0;
        chk("b_stream_count", 32'(ba.size()), 32'd6);
        for (int i = 0; i < ba.size(); i++) begin
            chk("b_stream_addr", 32'(ba[i]), 32'(11'h100 + 11'(i)));
            chk("b_stream_data", bd[i], BASE ^ (32'h100 + 32'(i)));
            if (i > 0) chk("b_stream_spacing", 32'(be[i] - be[i-1]), 32'd2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
